// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
// Multi-master to multi-slave single-outstanding interconnect. One transaction
// is in flight at a time: a master wins arbitration, its request is registered
// onto the slave side, the addressed slave is selected for one cycle and its
// read data is returned to the master one cycle later.
//
// Ports
//   clk_i        system clock, all state on rising edge
//   reset_i      synchronous active-high reset
//   m_req_i      per-master request, held until m_gnt_o is seen
//   m_we_i       per-master write enable
//   m_lock_i     per-master lock, keeps ownership across back-to-back transfers
//   m_addr_i     per-master address (packed, master 0 in the low bits)
//   m_wdata_i    per-master write data (packed)
//   m_gnt_o      onehot pulse: request accepted
//   m_rvalid_o   onehot pulse: m_rdata_o valid for that master
//   m_rdata_o    shared read data, held until the next response
//   s_cs_o       onehot slave select, asserted during ISSUE only
//   s_we_o       registered slave write enable
//   s_addr_o     registered slave address
//   s_wdata_o    registered slave write data
//   s_rdata_i    per-slave read data (packed, slave 0 in the low bits)
//
// state | meaning
// IDLE  | waiting for any request, arbitrate and load the slave bus
// ISSUE | slave selected, its read data captured
// RESP  | m_rvalid_o pulses; locked owner may re-issue directly
// ---------------------------------------------------------------------------
module bus_interconnect #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int ARB_MODE    = 0,
    parameter int LOCK_MAX    = 160,
    parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLV_BASE =
        {16'hE000, 16'hC000, 16'h8000, 16'h0000},
    parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLV_MASK =
        {16'hF000, 16'hE000, 16'hC000, 16'h8000}
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_MASTERS-1:0]        m_req_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_lock_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]        m_gnt_o,
    output logic [NUM_MASTERS-1:0]        m_rvalid_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic [NUM_SLAVES-1:0]         s_cs_o,
    output logic                          s_we_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [LCNT_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0]   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic                     s_we_q, s_we_d;
    logic [ADDR_W-1:0]        s_addr_q, s_addr_d;
    logic [DATA_W-1:0]        s_wdata_q, s_wdata_d;

    logic                     win_valid;
    logic [IDX_W-1:0]         win_idx;
    int                       cand;
    logic                     slv_hit;
    logic [SIDX_W-1:0]        slv_sel;
    logic [DATA_W-1:0]        sel_rdata;
    logic                     load_en;
    logic [IDX_W-1:0]         load_idx;

    // Arbitration. Round-robin searches from the slot after the last grant.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_req_i[i]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int off = 1; off <= NUM_MASTERS; off++) begin
                cand = (int'(rr_ptr_q) + off) % NUM_MASTERS;
                if (!win_valid && m_req_i[cand]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(cand);
                end
            end
        end
    end

    // Address decode; descending scan so the lowest matching slave wins.
    always_comb begin
        slv_hit = 1'b0;
        slv_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((s_addr_q & SLV_MASK[i]) == SLV_BASE[i]) begin
                slv_hit = 1'b1;
                slv_sel = SIDX_W'(i);
            end
        end
        sel_rdata = slv_hit ? s_rdata_i[slv_sel*DATA_W +: DATA_W] : '1;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = '0;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        load_en    = 1'b0;
        load_idx   = owner_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    load_en    = 1'b1;
                    load_idx   = win_idx;
                    owner_d    = win_idx;
                    rr_ptr_d   = win_idx;
                    lock_cnt_d = '0;
                    gnt_d      = NUM_MASTERS'(1) << win_idx;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rdata_d  = sel_rdata;
                rvalid_d = NUM_MASTERS'(1) << owner_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                // Locked owner skips arbitration until it has used its quota.
                if (m_lock_i[owner_q] && m_req_i[owner_q] &&
                    (lock_cnt_q < LCNT_W'(LOCK_MAX))) begin
                    load_en    = 1'b1;
                    load_idx   = owner_q;
                    gnt_d      = NUM_MASTERS'(1) << owner_q;
                    lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_en) begin
            s_we_d    = m_we_i[load_idx];
            s_addr_d  = m_addr_i[load_idx*ADDR_W +: ADDR_W];
            s_wdata_d = m_wdata_i[load_idx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= IDX_W'(NUM_MASTERS - 1);
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '1;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
        end
    end

    // Unmapped addresses never raise a select, so writes there are dropped.
    assign s_cs_o     = (state_q == ST_ISSUE && slv_hit) ? (NUM_SLAVES'(1) << slv_sel) : '0;
    assign m_gnt_o    = gnt_q;
    assign m_rvalid_o = rvalid_q;
    assign m_rdata_o  = rdata_q;
    assign s_we_o     = s_we_q;
    assign s_addr_o   = s_addr_q;
    assign s_wdata_o  = s_wdata_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: a fixed-priority instance (LOCK_MAX=4) and a
// round-robin instance share all inputs except m_req.
module tb_bus_interconnect;

    localparam int NM = 3;
    localparam int NS = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    // slave 3 (D000/F000) lies inside slave 1 (C000/E000): slave 1 must win.
    localparam logic [NS-1:0][AW-1:0] MAP_BASE = {16'hD000, 16'h8000, 16'hC000, 16'h0000};
    localparam logic [NS-1:0][AW-1:0] MAP_MASK = {16'hF000, 16'hC000, 16'hE000, 16'h8000};

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0][NM-1:0]   req;
    logic [NM-1:0]        we, lock;
    logic [NM*AW-1:0]     addr;
    logic [NM*DW-1:0]     wdata;
    logic [NS*DW-1:0]     srd;
    logic [1:0][NM-1:0]   gnt, rv;
    logic [1:0][DW-1:0]   rd, swd;
    logic [1:0][NS-1:0]   cs;
    logic [1:0]           swe;
    logic [1:0][AW-1:0]   saddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_interconnect #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
                       .ARB_MODE(0), .LOCK_MAX(4), .SLV_BASE(MAP_BASE), .SLV_MASK(MAP_MASK))
    dut_fx (.clk_i(clk), .reset_i(rst), .m_req_i(req[0]), .m_we_i(we), .m_lock_i(lock),
            .m_addr_i(addr), .m_wdata_i(wdata), .m_gnt_o(gnt[0]), .m_rvalid_o(rv[0]),
            .m_rdata_o(rd[0]), .s_cs_o(cs[0]), .s_we_o(swe[0]), .s_addr_o(saddr[0]),
            .s_wdata_o(swd[0]), .s_rdata_i(srd));

    bus_interconnect #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
                       .ARB_MODE(1), .SLV_BASE(MAP_BASE), .SLV_MASK(MAP_MASK))
    dut_rr (.clk_i(clk), .reset_i(rst), .m_req_i(req[1]), .m_we_i(we), .m_lock_i(lock),
            .m_addr_i(addr), .m_wdata_i(wdata), .m_gnt_o(gnt[1]), .m_rvalid_o(rv[1]),
            .m_rdata_o(rd[1]), .s_cs_o(cs[1]), .s_we_o(swe[1]), .s_addr_o(saddr[1]),
            .s_wdata_o(swd[1]), .s_rdata_i(srd));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [AW-1:0] a);
        int d = -1;
        for (int i = 0; i < NS; i++)
            if (d < 0 && ((a & MAP_MASK[i]) == MAP_BASE[i])) d = i;
        return d;
    endfunction

    function automatic logic [NS-1:0] ref_cs(input logic [AW-1:0] a);
        int d = dec(a);
        return (d < 0) ? '0 : NS'(1 << d);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a, input logic [NS*DW-1:0] s);
        int d = dec(a);
        return (d < 0) ? 8'hFF : s[d*DW +: DW];
    endfunction

    function automatic int winner(input logic [NM-1:0] r, input int mode, input int lst);
        if (mode == 0) begin
            for (int i = 0; i < NM; i++) if (r[i]) return i;
        end else begin
            for (int o = 1; o <= NM; o++) if (r[(lst + o) % NM]) return (lst + o) % NM;
        end
        return -1;
    endfunction

    task automatic set_master(input int m, input logic [AW-1:0] a, input logic w,
                              input logic [DW-1:0] d);
        addr[m*AW +: AW]  = a;
        we[m]             = w;
        wdata[m*DW +: DW] = d;
    endtask

    // Waits (bounded) for a grant on instance k; idx stays -1 on timeout.
    task automatic wait_gnt(input int k, input int budget, output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        while (idx < 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NM; i++) if (gnt[k][i]) idx = i;
        end
    endtask

    typedef struct {
        int              m;
        logic [AW-1:0]   a;
        logic            w;
        logic [DW-1:0]   wd;
        logic [NS-1:0]   cs;
        logic [DW-1:0]   rd;
    } vec_t;
    vec_t tbl[8];

    int stage[2], own[2], last[2];
    logic [NM-1:0] e_gnt[2], e_rv[2];
    logic [DW-1:0] e_rd[2], e_wd[2];
    logic [AW-1:0] e_addr[2];
    logic          e_we[2];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cyc, w;

        tbl[0] = '{0, 16'hC000, 1'b0, 8'h00, 4'b0010, 8'h5A};
        tbl[1] = '{2, 16'h1234, 1'b1, 8'h77, 4'b0001, 8'hC3};
        tbl[2] = '{1, 16'h9ABC, 1'b0, 8'h11, 4'b0100, 8'hA5};
        tbl[3] = '{0, 16'hD123, 1'b0, 8'h22, 4'b0010, 8'h5A};
        tbl[4] = '{1, 16'hFEA0, 1'b0, 8'h33, 4'b0000, 8'hFF};
        tbl[5] = '{2, 16'hE000, 1'b1, 8'h44, 4'b0000, 8'hFF};
        tbl[6] = '{0, 16'h7FFF, 1'b0, 8'h55, 4'b0001, 8'hC3};
        tbl[7] = '{0, 16'h8000, 1'b1, 8'h66, 4'b0100, 8'hA5};

        rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        srd = 32'h33A55AC3;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", 32'(gnt[k]), 0);
            chk("rst_rvalid", 32'(rv[k]), 0);
            chk("rst_rdata", 32'(rd[k]), 32'hFF);
            chk("rst_cs", 32'(cs[k]), 0);
            chk("rst_swe", 32'(swe[k]), 0);
            chk("rst_saddr", 32'(saddr[k]), 0);
            chk("rst_swdata", 32'(swd[k]), 0);
        end
        rst = 1'b0;

        // Single transactions through the fixed instance.
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            set_master(tbl[t].m, tbl[t].a, tbl[t].w, tbl[t].wd);
            req[0][tbl[t].m] = 1'b1;
            chk("vec_gnt_early", 32'(gnt[0]), 0);
            @(negedge clk);
            req[0][tbl[t].m] = 1'b0;
            chk("vec_gnt", 32'(gnt[0]), 32'(1 << tbl[t].m));
            chk("vec_cs", 32'(cs[0]), 32'(tbl[t].cs));
            chk("vec_saddr", 32'(saddr[0]), 32'(tbl[t].a));
            chk("vec_swe", 32'(swe[0]), 32'(tbl[t].w));
            chk("vec_swdata", 32'(swd[0]), 32'(tbl[t].wd));
            @(negedge clk);
            chk("vec_rvalid", 32'(rv[0]), 32'(1 << tbl[t].m));
            chk("vec_rdata", 32'(rd[0]), 32'(tbl[t].rd));
            chk("vec_cs_off", 32'(cs[0]), 0);
            @(negedge clk);
            chk("vec_rvalid_off", 32'(rv[0]), 0);
            chk("vec_rdata_hold", 32'(rd[0]), 32'(tbl[t].rd));
        end

        // Fixed priority: master 0 keeps winning until it lets go.
        @(negedge clk);
        set_master(0, 16'h0100, 1'b0, 8'h00);
        set_master(1, 16'h8100, 1'b0, 8'h00);
        set_master(2, 16'hC100, 1'b0, 8'h00);
        req[0] = 3'b111;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(0, 10, idx, cyc);
            chk("fix_order", 32'(idx), 0);
            chk("fix_cadence", 32'(cyc), (n == 0) ? 1 : 3);
        end
        req[0][0] = 1'b0;
        wait_gnt(0, 10, idx, cyc);
        chk("fix_after_release", 32'(idx), 1);
        chk("fix_cadence", 32'(cyc), 3);
        req[0] = '0;
        repeat (3) @(negedge clk);

        // Round robin: 0,1,2,0 with everyone requesting.
        req[1] = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(1, 10, idx, cyc);
            chk("rr_order", 32'(idx), 32'(n % NM));
            if (n > 0) chk("rr_cadence", 32'(cyc), 3);
        end
        req[1] = '0;
        repeat (3) @(negedge clk);

        // Lock: master 1 re-issues LOCK_MAX times, then master 0 gets in.
        // Master 1 then wins again unlocked and must get a fresh quota.
        set_master(0, 16'hC000, 1'b0, 8'h00);
        set_master(1, 16'hC004, 1'b0, 8'h00);
        req[0][1] = 1'b1;
        lock[1]   = 1'b1;
        wait_gnt(0, 10, idx, cyc);
        chk("lock_first", 32'(idx), 1);
        req[0][0] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_gnt(0, 10, idx, cyc);
            chk("lock_reissue", 32'(idx), 1);
            chk("lock_cadence", 32'(cyc), 2);
        end
        wait_gnt(0, 10, idx, cyc);
        chk("lock_release_to_m0", 32'(idx), 0);
        chk("lock_release_cadence", 32'(cyc), 3);
        req[0][0] = 1'b0;
        wait_gnt(0, 10, idx, cyc);
        chk("lock_regrant", 32'(idx), 1);
        for (int r = 0; r < 4; r++) begin
            wait_gnt(0, 10, idx, cyc);
            chk("lock_quota_cleared", 32'(idx), 1);
            chk("lock_cadence2", 32'(cyc), 2);
        end
        req[0] = '0;
        lock   = '0;
        repeat (3) @(negedge clk);
        chk("lock_rdata", 32'(rd[0]), 32'h5A);

        // Reset during ISSUE aborts the transfer.
        set_master(0, 16'hC000, 1'b0, 8'h00);
        req[0][0] = 1'b1;
        wait_gnt(0, 10, idx, cyc);
        chk("rst_mid_gnt", 32'(idx), 0);
        rst    = 1'b1;
        req[0] = '0;
        @(negedge clk);
        chk("rst_mid_rvalid", 32'(rv[0]), 0);
        chk("rst_mid_cs", 32'(cs[0]), 0);
        chk("rst_mid_rdata", 32'(rd[0]), 32'hFF);
        chk("rst_mid_gnt_off", 32'(gnt[0]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_resp", 32'(rv[0]), 0);
        req[0][0] = 1'b1;
        @(negedge clk);
        req[0][0] = 1'b0;
        chk("rst_mid_idle_grant", 32'(gnt[0]), 1);
        repeat (3) @(negedge clk);

        // Randomized traffic on both instances against a transaction model.
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stage[k] = 0; own[k] = 0; last[k] = NM - 1;
            e_gnt[k] = '0; e_rv[k] = '0; e_rd[k] = 8'hFF;
            e_addr[k] = '0; e_we[k] = 1'b0; e_wd[k] = '0;
        end
        repeat (500) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("rnd_gnt", 32'(gnt[k]), 32'(e_gnt[k]));
                chk("rnd_rvalid", 32'(rv[k]), 32'(e_rv[k]));
                chk("rnd_rdata", 32'(rd[k]), 32'(e_rd[k]));
                if (stage[k] == 1) begin
                    chk("rnd_cs", 32'(cs[k]), 32'(ref_cs(e_addr[k])));
                    chk("rnd_saddr", 32'(saddr[k]), 32'(e_addr[k]));
                    chk("rnd_swe", 32'(swe[k]), 32'(e_we[k]));
                    chk("rnd_swdata", 32'(swd[k]), 32'(e_wd[k]));
                end else begin
                    chk("rnd_cs_idle", 32'(cs[k]), 0);
                end
            end
            srd = $urandom;
            for (int m = 0; m < NM; m++) begin
                for (int k = 0; k < 2; k++) begin
                    if (gnt[k][m]) req[k][m] = 1'($urandom_range(0, 1));
                    else if (req[k][m]) begin
                        if ($urandom_range(0, 7) == 0) req[k][m] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) req[k][m] = 1'b1;
                end
                if (!req[0][m] && !req[1][m])
                    set_master(m, 16'($urandom), 1'($urandom), 8'($urandom));
            end
            for (int k = 0; k < 2; k++) begin
                case (stage[k])
                    0: begin
                        e_rv[k] = '0;
                        if (req[k] != 0) begin
                            w = winner(req[k], k, last[k]);
                            e_gnt[k]  = NM'(1 << w);
                            e_addr[k] = addr[w*AW +: AW];
                            e_we[k]   = we[w];
                            e_wd[k]   = wdata[w*DW +: DW];
                            own[k]    = w;
                            last[k]   = w;
                            stage[k]  = 1;
                        end else begin
                            e_gnt[k] = '0;
                        end
                    end
                    1: begin
                        e_gnt[k] = '0;
                        e_rv[k]  = NM'(1 << own[k]);
                        e_rd[k]  = ref_rd(e_addr[k], srd);
                        stage[k] = 2;
                    end
                    default: begin
                        e_gnt[k] = '0;
                        e_rv[k]  = '0;
                        stage[k] = 0;
                    end
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
